// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: loopback monitor for the multiplexed 7-segment display.
// Registers anode/eSeg, decodes each settled digit into its slot, and
// publishes a 16-bit BCD frame once consecutive complete scans agree.
// Optional build macro: SEG_DECODE_HEX_EN adds the A-F glyphs to the decoder.
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned STABLE_FRAMES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic        clk_osc,
    input  logic        reset,
    input  logic [3:0]  anode,
    input  logic [6:0]  eSeg,
    output logic [15:0] frame,
    output logic [3:0]  blank_mask,
    output logic [3:0]  err_mask,
    output logic        frame_valid,
    output logic        locked
);

    typedef enum logic [1:0] {WAIT, SETTLE, HELD} state_t;

    localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [2:0]  STABLE_CNT   = 3'(STABLE_FRAMES);
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  settle_cnt;
    logic [3:0]  a_q, a_p;
    logic [6:0]  s_q, s_p;
    logic        sel_valid, sel_changed, changed;
    logic [1:0]  slot;
    logic [3:0]  slot_bit;
    logic [3:0]  dec_val;
    logic        dec_blank, dec_err;
    logic        capture, complete, eligible, publish, timeout;
    logic [15:0] digits, cand_digits;
    logic [3:0]  blanks, errs, captured, cand_blanks, cand_errs;
    logic [23:0] cand, prev_cand;
    logic [2:0]  match_cnt, match_next;
    logic [19:0] idle_cnt;

    // Input register plus a one-cycle history used to detect any change
    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) begin
            a_q <= '1;
            s_q <= '1;
            a_p <= '1;
            s_p <= '1;
        end else begin
            a_q <= anode;
            s_q <= eSeg;
            a_p <= a_q;
            s_p <= s_q;
        end
    end

    // Digit select: exactly one active-low anode bit names the slot
    always_comb begin
        sel_valid = 1'b1;
        slot      = 2'd0;
        case (a_q)
            4'b1110: slot = 2'd0;
            4'b1101: slot = 2'd1;
            4'b1011: slot = 2'd2;
            4'b0111: slot = 2'd3;
            default: sel_valid = 1'b0;
        endcase
        slot_bit    = 4'b0001 << slot;
        sel_changed = (a_q != a_p);
        changed     = sel_changed || (s_q != s_p);
    end

    // Active-low glyph decode; unknown glyphs flag err, all-off flags blank
    always_comb begin
        dec_val   = 4'd0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (s_q)
            7'b1000000: dec_val = 4'h0;
            7'b1111001: dec_val = 4'h1;
            7'b0100100: dec_val = 4'h2;
            7'b0110000: dec_val = 4'h3;
            7'b0011001: dec_val = 4'h4;
            7'b0010010: dec_val = 4'h5;
            7'b0000010: dec_val = 4'h6;
            7'b1111000: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0010000: dec_val = 4'h9;
`ifdef SEG_DECODE_HEX_EN
            7'b0001000: dec_val = 4'hA;
            7'b0000011: dec_val = 4'hB;
            7'b1000110: dec_val = 4'hC;
            7'b0100001: dec_val = 4'hD;
            7'b0000110: dec_val = 4'hE;
            7'b0001110: dec_val = 4'hF;
`endif
            7'b1111111: dec_blank = 1'b1;
            default:    dec_err = 1'b1;
        endcase
    end

    // Candidate frame, stability tracking and publish decision
    always_comb begin
        capture     = (state == SETTLE) && !changed && (settle_cnt == SETTLE_LAST);
        cand_digits = digits;
        cand_blanks = blanks;
        cand_errs   = errs;
        cand_digits[{slot, 2'b00} +: 4] = dec_val;
        cand_blanks[slot] = dec_blank;
        cand_errs[slot]   = dec_err;
        cand     = {cand_digits, cand_blanks, cand_errs};
        complete = capture && ((captured | slot_bit) == 4'b1111);
        // match_cnt == 0 means no earlier candidate to compare against
        if ((match_cnt != 3'd0) && (cand == prev_cand))
            match_next = (match_cnt >= STABLE_CNT) ? STABLE_CNT : match_cnt + 3'd1;
        else
            match_next = 3'd1;
        eligible = (match_next >= STABLE_CNT);
        publish  = complete && eligible &&
                   (!locked || (cand != {frame, blank_mask, err_mask}));
        timeout  = !capture && (idle_cnt == TIMEOUT_LAST);
    end

    // Sampling FSM: wait for a select, let it settle, then hold until it moves
    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) begin
            state      <= WAIT;
            settle_cnt <= '0;
        end else begin
            case (state)
                WAIT: begin
                    settle_cnt <= '0;
                    if (sel_valid) state <= SETTLE;
                end
                SETTLE: begin
                    if (changed) begin
                        settle_cnt <= '0;
                        state      <= sel_valid ? SETTLE : WAIT;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state <= HELD;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                HELD: begin
                    if (sel_changed) begin
                        settle_cnt <= '0;
                        state      <= sel_valid ? SETTLE : WAIT;
                    end
                end
                default: begin
                    state      <= WAIT;
                    settle_cnt <= '0;
                end
            endcase
        end
    end

    // Frame assembly, publish registers and loss-of-lock timeout
    always_ff @(posedge clk_osc or posedge reset) begin
        if (reset) begin
            digits      <= '0;
            blanks      <= '0;
            errs        <= '0;
            captured    <= '0;
            prev_cand   <= '0;
            match_cnt   <= '0;
            idle_cnt    <= '0;
            frame       <= '0;
            blank_mask  <= '0;
            err_mask    <= '0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
        end else begin
            frame_valid <= publish;
            if (capture) begin
                digits   <= cand_digits;
                blanks   <= cand_blanks;
                errs     <= cand_errs;
                idle_cnt <= '0;
                captured <= complete ? 4'b0000 : (captured | slot_bit);
                if (complete) begin
                    prev_cand <= cand;
                    match_cnt <= match_next;
                end
                if (publish) begin
                    frame      <= cand_digits;
                    blank_mask <= cand_blanks;
                    err_mask   <= cand_errs;
                    locked     <= 1'b1;
                end
            end else if (timeout) begin
                locked    <= 1'b0;
                captured  <= '0;
                match_cnt <= '0;
                idle_cnt  <= '0;
            end else begin
                idle_cnt <= idle_cnt + 20'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: randomized scans of the display lines checked
// cycle by cycle against a history-based reference model of the decoder.
module tb_seg_scan_decoder;

    localparam int unsigned S  = 4;
    localparam int unsigned SF = 2;
    localparam int unsigned T  = 4096;

    logic        clk_osc = 1'b0;
    logic        reset   = 1'b1;
    logic [3:0]  anode   = 4'b1111;
    logic [6:0]  eSeg    = 7'b1111111;
    logic [15:0] frame;
    logic [3:0]  blank_mask, err_mask;
    logic        frame_valid, locked;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned pulse_total = 0;

    seg_scan_decoder #(
        .SETTLE_CYCLES(S),
        .STABLE_FRAMES(SF),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_osc(clk_osc),
        .reset(reset),
        .anode(anode),
        .eSeg(eSeg),
        .frame(frame),
        .blank_mask(blank_mask),
        .err_mask(err_mask),
        .frame_valid(frame_valid),
        .locked(locked)
    );

    always #5 clk_osc = ~clk_osc;

    // Reference glyphs, index = digit value
    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [3:0] a; logic [6:0] s; } samp_t;
    samp_t       hist[$];
    logic [15:0] m_dig;
    logic [3:0]  m_blk, m_err, m_cap;
    logic [23:0] m_prev;
    bit          m_prev_ok, m_held;
    logic [3:0]  m_held_a;
    int unsigned m_match, m_idle;
    logic [15:0] m_frame;
    logic [3:0]  m_blank, m_errm;
    bit          m_fv, m_locked;

    function automatic void decode(input logic [6:0] p, output logic [3:0] v,
                                   output logic b, output logic e);
        int unsigned top;
`ifdef SEG_DECODE_HEX_EN
        top = 15;
`else
        top = 9;
`endif
        v = 4'd0; b = 1'b0; e = 1'b1;
        for (int unsigned i = 0; i <= top; i++)
            if (p == glyph[i]) begin v = 4'(i); e = 1'b0; end
        if (p == 7'b1111111) begin b = 1'b1; e = 1'b0; end
    endfunction

    task automatic model_clear();
        hist.delete();
        for (int unsigned i = 0; i < S + 1; i++) hist.push_back({4'b1111, 7'b1111111});
        m_dig = '0; m_blk = '0; m_err = '0; m_cap = '0; m_prev = '0;
        m_prev_ok = 0; m_held = 0; m_held_a = '0; m_match = 0; m_idle = 0;
        m_frame = '0; m_blank = '0; m_errm = '0; m_fv = 0; m_locked = 0;
    endtask

    // One clock edge: act on the registered view (last sample), then record the new one
    task automatic model_step(input samp_t now);
        samp_t       last;
        bit          same;
        int unsigned slot;
        logic [3:0]  v;
        logic        b, e;
        logic [23:0] cand;
        last = hist[$];
        same = 1;
        foreach (hist[i]) if (hist[i] != last) same = 0;
        m_fv = 0;
        if (m_held && last.a != m_held_a) m_held = 0;
        if (!m_held && $countones(~last.a) == 1 && same) begin
            slot = 0;
            for (int unsigned i = 0; i < 4; i++) if (!last.a[i]) slot = i;
            decode(last.s, v, b, e);
            m_dig[slot*4 +: 4] = v;
            m_blk[slot] = b;
            m_err[slot] = e;
            m_cap[slot] = 1'b1;
            m_held = 1; m_held_a = last.a; m_idle = 0;
            if (m_cap == 4'b1111) begin
                m_cap = '0;
                cand = {m_dig, m_blk, m_err};
                if (m_prev_ok && cand == m_prev) m_match = (m_match < SF) ? m_match + 1 : SF;
                else m_match = 1;
                m_prev = cand; m_prev_ok = 1;
                if (m_match >= SF && (!m_locked || cand != {m_frame, m_blank, m_errm})) begin
                    {m_frame, m_blank, m_errm} = cand;
                    m_fv = 1; m_locked = 1;
                end
            end
        end else begin
            m_idle++;
            if (m_idle == T) begin
                m_locked = 0; m_cap = '0; m_prev_ok = 0; m_match = 0; m_idle = 0;
            end
        end
        hist.push_back(now);
        void'(hist.pop_front());
    endtask

    // Model advances on the same edges as the design
    always @(posedge clk_osc or posedge reset) begin
        if (reset) model_clear();
        else model_step({anode, eSeg});
    end

    // Compare every output against the model away from the active edge
    always @(negedge clk_osc) begin
        if (!reset) begin
            check_eq("frame", 32'(frame), 32'(m_frame));
            check_eq("blank_mask", 32'(blank_mask), 32'(m_blank));
            check_eq("err_mask", 32'(err_mask), 32'(m_errm));
            check_eq("frame_valid", 32'(frame_valid), 32'(m_fv));
            check_eq("locked", 32'(locked), 32'(m_locked));
            if (frame_valid) pulse_total++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic show(input int unsigned d, input logic [6:0] pat, input int unsigned len);
        anode = ~(4'b0001 << d);
        eSeg  = pat;
        repeat (len) @(negedge clk_osc);
    endtask

    function automatic logic [27:0] pats_of(input logic [15:0] d);
        logic [27:0] p;
        for (int unsigned i = 0; i < 4; i++) p[i*7 +: 7] = glyph[d[i*4 +: 4]];
        return p;
    endfunction

    task automatic scan_pats(input logic [27:0] pats, input int unsigned n, input bit glitch);
        for (int unsigned k = 0; k < n; k++)
            for (int unsigned d = 0; d < 4; d++) begin
                if (glitch) show(d, 7'($urandom_range(0, 127)), 2);
                show(d, pats[d*7 +: 7], $urandom_range(12, 40));
                if ($urandom_range(0, 3) == 0) begin
                    anode = 4'b1111;
                    repeat ($urandom_range(1, 3)) @(negedge clk_osc);
                end
            end
    endtask

    task automatic pulse_reset(input bit level);
        @(negedge clk_osc);
        #2 reset = level;
    endtask

    initial begin
        int unsigned base;
        logic [27:0] p;
        logic [15:0] d;
        repeat (3) @(negedge clk_osc);
        check_eq("rst_frame", 32'(frame), 32'h0);
        check_eq("rst_blank", 32'(blank_mask), 32'h0);
        check_eq("rst_err", 32'(err_mask), 32'h0);
        check_eq("rst_valid", 32'(frame_valid), 32'h0);
        check_eq("rst_locked", 32'(locked), 32'h0);
        pulse_reset(1'b0);
        @(negedge clk_osc);

        // stable scan: one pulse after the second scan, none on the third
        base = pulse_total;
        scan_pats(pats_of(16'h1234), 2, 0);
        #1;
        check_eq("stable_pulses", pulse_total - base, 32'd1);
        check_eq("stable_frame", 32'(frame), 32'h1234);
        check_eq("stable_masks", {blank_mask, err_mask}, 32'h0);
        check_eq("stable_locked", 32'(locked), 32'h1);
        scan_pats(pats_of(16'h1234), 1, 0);
        #1 check_eq("third_scan_pulses", pulse_total - base, 32'd1);

        // glitches at each window start are never captured
        scan_pats(pats_of(16'h1234), 2, 1);
        #1 check_eq("glitch_frame", 32'(frame), 32'h1234);

        // blank on digit 2, unknown glyph on digit 1
        p = pats_of(16'h1004);
        p[2*7 +: 7] = 7'b1111111;
        p[1*7 +: 7] = 7'b1010101;
        scan_pats(p, 2, 0);
        #1;
        check_eq("be_frame", 32'(frame), 32'h1004);
        check_eq("be_blank", 32'(blank_mask), 32'b0100);
        check_eq("be_err", 32'(err_mask), 32'b0010);

        // all-on alarm flash
        scan_pats({4{7'b0000000}}, 2, 0);
        #1 check_eq("alarm_frame", 32'(frame), 32'h8888);

        // hex glyph A on digit 0
        scan_pats({glyph[7], glyph[6], glyph[5], 7'b0001000}, 2, 0);
        #1;
`ifdef SEG_DECODE_HEX_EN
        check_eq("hex_digit", 32'(frame[3:0]), 32'hA);
        check_eq("hex_err", 32'(err_mask), 32'h0);
`else
        check_eq("hex_digit", 32'(frame[3:0]), 32'h0);
        check_eq("hex_err", 32'(err_mask), 32'b0001);
`endif

        // random content, scan counts and glitches
        for (int unsigned r = 0; r < 8; r++) begin
            for (int unsigned i = 0; i < 4; i++) d[i*4 +: 4] = 4'($urandom_range(0, 9));
            p = pats_of(d);
            if ($urandom_range(0, 2) == 0) p[$urandom_range(0, 3)*7 +: 7] = 7'($urandom_range(0, 127));
            scan_pats(p, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
        end

        // timeout: lock on 1234, go idle, then relock
        scan_pats(pats_of(16'h1234), 2, 0);
        #1 check_eq("pre_timeout_locked", 32'(locked), 32'h1);
        anode = 4'b1111;
        repeat (T + 20) @(negedge clk_osc);
        #1;
        check_eq("timeout_locked", 32'(locked), 32'h0);
        check_eq("timeout_frame", 32'(frame), 32'h1234);
        base = pulse_total;
        scan_pats(pats_of(16'h1234), 2, 0);
        #1;
        check_eq("relock_locked", 32'(locked), 32'h1);
        check_eq("relock_pulses", pulse_total - base, 32'd1);

        // reset after two digits of a frame
        show(0, glyph[4], 20);
        show(1, glyph[3], 20);
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_frame", 32'(frame), 32'h0);
        check_eq("midrst_locked", 32'(locked), 32'h0);
        check_eq("midrst_masks", {blank_mask, err_mask}, 32'h0);
        pulse_reset(1'b0);
        @(negedge clk_osc);
        base = pulse_total;
        scan_pats(pats_of(16'h5678), 1, 0);
        #1 check_eq("post_rst_one_scan", pulse_total - base, 32'd0);
        scan_pats(pats_of(16'h5678), 1, 0);
        #1;
        check_eq("post_rst_two_scans", pulse_total - base, 32'd1);
        check_eq("post_rst_frame", 32'(frame), 32'h5678);

        repeat (4) @(negedge clk_osc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
